// File: rtl/ota_sd_decimator.sv
// First-order sigma-delta decimator for a digital-OTA comparator loop.
// Each window of 2^WIDTH cycles counts the ones in the comparator stream.
// The count is saturated and delivered through a valid/ready handshake.
// Build option: define OTA_IN_SYNC_EN to sample cmp_in through a two-flop
// synchronizer. Otherwise cmp_in goes through a single register.
module ota_sd_decimator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmp_in,
    output logic             fb_out,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [WIDTH:0] WIN_LEN = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] ONE     = {{WIDTH{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH:0]   cnt_q, cnt_d, cnt_inc;
    logic [WIDTH:0]   acc_q, acc_d, acc_inc;
    logic [WIDTH-1:0] sat;
    logic             s, complete, accept;

`ifdef OTA_IN_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchronizer for the asynchronous comparator bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= cmp_in;
            sync2_q <= sync1_q;
        end
    end
    assign s = sync2_q;
`else
    logic samp_q;

    // Single sampling register for the comparator bit.
    always_ff @(posedge clk) begin
        if (rst) samp_q <= 1'b0;
        else     samp_q <= cmp_in;
    end
    assign s = samp_q;
`endif

    assign cnt_inc = cnt_q + ONE;
    assign acc_inc = acc_q + {{WIDTH{1'b0}}, s};
    // An all-ones window would wrap to 0. Clamp it to full scale instead.
    assign sat     = acc_inc[WIDTH] ? {WIDTH{1'b1}} : acc_inc[WIDTH-1:0];
    assign accept  = result_valid & result_ready;
    assign busy    = (state_q == RUN);

    // Next-state logic, window counting and completion detect.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                if (!en) begin
                    // Abort: the partial window is dropped.
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (cnt_inc == WIN_LEN) begin
                    // Start the next window on the following cycle, with no gap.
                    complete = 1'b1;
                    cnt_d    = '0;
                    acc_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                    acc_d = acc_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, counters and feedback bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            fb_out  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            fb_out  <= (state_d == RUN) ? s : 1'b0;
        end
    end

    // Result register with valid/ready handshake and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (complete) begin
            result       <= sat;
            result_valid <= 1'b1;
            // An accept on the same edge consumed the old value, so nothing was lost.
            if (accept)            overrun <= 1'b0;
            else if (result_valid) overrun <= 1'b1;
        end else if (accept) begin
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end
    end

endmodule
